// File: rtl/alu_exec_unit.sv
// Registered ALU execution stage: decodes ALUOp/funct3, runs single-cycle ops in one cycle,
// and multiplies iteratively by shift-add, with valid/ready on both sides and branch flags.
module alu_exec_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [2:0]       alu_ctrl,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int ITERS = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [2:0] C_SUB = 3'b000;
  localparam logic [2:0] C_MUL = 3'b001;
  localparam logic [2:0] C_OR  = 3'b010;
  localparam logic [2:0] C_SLL = 3'b011;
  localparam logic [2:0] C_CMM = 3'b100;
  localparam logic [2:0] C_CME = 3'b101;
  localparam logic [2:0] C_CMP = 3'b110;
  localparam logic [2:0] C_ADD = 3'b111;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_next, alu_res;
  logic [CW-1:0]    cnt;
  logic [2:0]       dec;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic             accept, lt, eq, is_arith, nxt_c, nxt_v;

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    dec = C_OR;
    if (alu_op == 2'b01) begin
      case (funct3)
        3'b001:  dec = C_SUB;
        3'b010:  dec = C_MUL;
        3'b011:  dec = C_OR;
        3'b100:  dec = C_SLL;
        default: dec = C_OR;
      endcase
    end else if (alu_op == 2'b00) begin
      case (funct3)
        3'b111:  dec = C_ADD;
        3'b101:  dec = C_CMM;
        3'b110:  dec = C_CME;
        3'b000:  dec = C_CMP;
        default: dec = C_OR;
      endcase
    end
  end

  // Subtract as A + ~B + 1 so the top bit is the not-borrow carry.
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign dif_ext  = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
  assign lt       = $signed(op_a) < $signed(op_b);
  assign eq       = (op_a == op_b);
  assign is_arith = (dec == C_ADD) || (dec == C_SUB) || (dec == C_CMP);

  always_comb begin
    alu_res = '0;
    nxt_c   = 1'b0;
    nxt_v   = 1'b0;
    case (dec)
      C_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        nxt_c   = sum_ext[WIDTH];
        nxt_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
      end
      C_SUB, C_CMP: begin
        alu_res = dif_ext[WIDTH-1:0];
        nxt_c   = dif_ext[WIDTH];
        nxt_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (dif_ext[WIDTH-1] != op_a[WIDTH-1]);
      end
      C_OR:    alu_res = op_a | op_b;
      C_SLL:   alu_res = op_a << op_b[SHW-1:0];
      C_CMM:   alu_res = {{(WIDTH-1){1'b0}}, lt};
      C_CME:   alu_res = {{(WIDTH-1){1'b0}}, lt | eq};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step consumes MUL_BITS multiplier bits; upper product bits fall off.
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier[j]) acc_next = acc_next + (mcand << j);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      alu_ctrl  <= 3'b000;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            alu_ctrl <= dec;
            if (dec == C_MUL) begin
              acc       <= '0;
              mcand     <= op_a;
              mplier    <= op_b;
              cnt       <= '0;
              out_valid <= 1'b0;
              state     <= MUL;
            end else begin
              res       <= alu_res;
              out_valid <= 1'b1;
              state     <= HOLD;
              if (is_arith) begin
                flag_z <= (alu_res == '0);
                flag_n <= alu_res[WIDTH-1];
                flag_c <= nxt_c;
                flag_v <= nxt_v;
              end
            end
          end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) begin
            res       <= acc_next;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; a second instance covers MUL_BITS=4 latency.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_valid4, flush, out_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        in_ready, out_valid, flag_z, flag_n, flag_c, flag_v;
  logic [31:0] res;
  logic [2:0]  alu_ctrl;
  logic        in_ready4, out_valid4, flag_z4, flag_n4, flag_c4, flag_v4;
  logic [31:0] res4;
  logic [2:0]  alu_ctrl4;

  int errors = 0;
  int checks = 0;
  int cycles;
  bit sawReady, sawValid, holdOk;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .op_a(op_a), .op_b(op_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .alu_ctrl(alu_ctrl),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  alu_exec_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_op(alu_op), .funct3(funct3), .op_a(op_a), .op_b(op_b), .flush(1'b0),
    .out_valid(out_valid4), .out_ready(out_ready), .res(res4), .alu_ctrl(alu_ctrl4),
    .flag_z(flag_z4), .flag_n(flag_n4), .flag_c(flag_c4), .flag_v(flag_v4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b);
    alu_op   = op;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; returns the accept-to-out_valid latency in cycles.
  task automatic waitValid(input bit sel4, output int lat);
    lat      = 1;
    sawReady = 1'b0;
    while (((sel4 ? out_valid4 : out_valid) !== 1'b1) && lat < 100) begin
      if ((sel4 ? in_ready4 : in_ready) !== 1'b0) sawReady = 1'b1;
      step();
      lat++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'b000; op_a = '0; op_b = '0;
    step();
    step();
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_res", res, 32'd0);
    checkOutput("reset_ctrl", {29'd0, alu_ctrl}, 32'd0);
    checkOutput("reset_flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();

    applyStimulus(2'b00, 3'b111, 32'h7FFF_FFFF, 32'd1);
    checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("add_res", res, 32'h8000_0000);
    checkOutput("add_ctrl", {29'd0, alu_ctrl}, 32'd7);
    checkOutput("add_flags_znvc", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b0101);

    applyStimulus(2'b00, 3'b000, 32'h1234, 32'h1234);
    checkOutput("cmp_res", res, 32'd0);
    checkOutput("cmp_ctrl", {29'd0, alu_ctrl}, 32'd6);
    checkOutput("cmp_flags_znvc", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b1010);

    applyStimulus(2'b00, 3'b101, 32'hFFFF_FFFF, 32'd1);
    checkOutput("cmm_res", res, 32'd1);
    checkOutput("cmm_ctrl", {29'd0, alu_ctrl}, 32'd4);
    checkOutput("cmm_flags_kept", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b1010);

    applyStimulus(2'b00, 3'b110, 32'd5, 32'd5);
    checkOutput("cme_res", res, 32'd1);
    checkOutput("cme_ctrl", {29'd0, alu_ctrl}, 32'd5);
    step();

    applyStimulus(2'b01, 3'b010, 32'd7, 32'd6);
    op_a = 32'hDEAD_BEEF;
    op_b = 32'h1357_9BDF;
    waitValid(1'b0, cycles);
    checkOutput("mul1_latency", cycles, 32'd33);
    checkOutput("mul1_res", res, 32'd42);
    checkOutput("mul1_ctrl", {29'd0, alu_ctrl}, 32'd1);
    checkOutput("mul1_no_ready", {31'd0, sawReady}, 32'd0);
    checkOutput("mul1_flags_kept", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b1010);
    step();

    alu_op = 2'b01; funct3 = 3'b010; op_a = 32'd7; op_b = 32'd6;
    in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    op_a = 32'hFFFF_FFFF;
    waitValid(1'b1, cycles);
    checkOutput("mul4_latency", cycles, 32'd9);
    checkOutput("mul4_res", res4, 32'd42);
    checkOutput("mul4_ctrl", {29'd0, alu_ctrl4}, 32'd1);
    checkOutput("mul4_no_ready", {31'd0, sawReady}, 32'd0);
    checkOutput("mul4_flags", {28'd0, flag_z4, flag_n4, flag_c4, flag_v4}, 32'd0);
    step();

    applyStimulus(2'b01, 3'b010, 32'h0001_0000, 32'h0001_0000);
    waitValid(1'b0, cycles);
    checkOutput("mul_wrap_latency", cycles, 32'd33);
    checkOutput("mul_wrap_res", res, 32'd0);
    step();

    out_ready = 1'b0;
    applyStimulus(2'b01, 3'b001, 32'd10, 32'd3);
    holdOk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (res !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) holdOk = 1'b0;
      step();
    end
    checkOutput("sub_hold_stable", {31'd0, holdOk}, 32'd1);
    checkOutput("sub_res", res, 32'd7);
    checkOutput("sub_flags_znvc", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b0010);
    out_ready = 1'b1;
    applyStimulus(2'b01, 3'b100, 32'd1, 32'h25);
    checkOutput("sll_res", res, 32'h20);
    checkOutput("sll_ctrl", {29'd0, alu_ctrl}, 32'd3);
    checkOutput("sll_valid", {31'd0, out_valid}, 32'd1);

    applyStimulus(2'b10, 3'b011, 32'hF0, 32'h0F);
    checkOutput("dflt10_res", res, 32'hFF);
    checkOutput("dflt10_ctrl", {29'd0, alu_ctrl}, 32'd2);
    applyStimulus(2'b01, 3'b000, 32'hF0, 32'h0F);
    checkOutput("dflt01_res", res, 32'hFF);
    checkOutput("dflt01_ctrl", {29'd0, alu_ctrl}, 32'd2);
    step();

    applyStimulus(2'b01, 3'b010, 32'd7, 32'd6);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b1;
    applyStimulus(2'b00, 3'b111, 32'h7FFF_FFFF, 32'd1);
    flush = 1'b0;
    checkOutput("flush_accept_dropped", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_flags_kept", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b0010);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) sawValid = 1'b1;
      step();
    end
    checkOutput("flush_no_result", {31'd0, sawValid}, 32'd0);

    applyStimulus(2'b01, 3'b010, 32'd7, 32'd6);
    for (int i = 0; i < 5; i++) step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_res", res, 32'd0);
    checkOutput("async_rst_ctrl", {29'd0, alu_ctrl}, 32'd0);
    checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    step();
    applyStimulus(2'b00, 3'b111, 32'd2, 32'd3);
    checkOutput("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("post_rst_add_res", res, 32'd5);
    checkOutput("post_rst_add_ctrl", {29'd0, alu_ctrl}, 32'd7);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
